// File: rtl/mul3_arbiter.sv
// Round-robin arbiter sharing one 3x3-bit unsigned multiplier between NREQ requesters.
// One operation in flight at a time: accept, multiply, then hold the product until consumed.
module mul3_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [3*NREQ-1:0]   req_a,
   input  logic [3*NREQ-1:0]   req_b,
   output logic [NREQ-1:0]     req_ready,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic [5:0]          rsp_p,
   output logic                busy,
   output logic [7:0]          op_count
);

   typedef enum logic [1:0] {StIdle, StMul, StResp} state_e;

   state_e         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [2:0]     op_a_q, op_b_q;
   logic [IDW-1:0] op_id_q;
   logic [5:0]     rsp_p_q;
   logic [IDW-1:0] rsp_id_q;
   logic [7:0]     op_count_q;

   logic           grant_found;
   int unsigned    grant_int;
   int unsigned    cand;
   logic [IDW-1:0] grant_idx;
   logic           accept;
   logic           handshake;

   // Search upward from ptr, wrapping modulo NREQ; first valid requester wins.
   always_comb begin
      grant_found = 1'b0;
      grant_int   = 0;
      cand        = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = 32'(ptr_q) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         if (!grant_found && req_valid[cand[IDW-1:0]]) begin
            grant_found = 1'b1;
            grant_int   = cand;
         end
      end
   end

   assign grant_idx = IDW'(grant_int);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      accept    = 1'b0;
      handshake = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (grant_found) begin
               accept  = 1'b1;
               state_d = StMul;
               ptr_d   = (grant_int == NREQ - 1) ? '0 : IDW'(grant_int + 1);
            end
         end
         StMul: state_d = StResp;
         StResp: begin
            if (rsp_ready) begin
               handshake = 1'b1;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Gated by rst_n so no requester sees an acceptance while reset is held.
   always_comb begin
      req_ready = '0;
      if (accept && rst_n) req_ready[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_id_q    <= '0;
         rsp_p_q    <= '0;
         rsp_id_q   <= '0;
         op_count_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         if (accept) begin
            op_a_q  <= req_a[3*grant_int +: 3];
            op_b_q  <= req_b[3*grant_int +: 3];
            op_id_q <= grant_idx;
         end
         if (state_q == StMul) begin
            rsp_p_q  <= {3'b000, op_a_q} * {3'b000, op_b_q};
            rsp_id_q <= op_id_q;
         end
         if (handshake) op_count_q <= op_count_q + 8'd1;
      end
   end

   assign rsp_valid = (state_q == StResp);
   assign busy      = (state_q != StIdle);
   assign rsp_p     = rsp_p_q;
   assign rsp_id    = rsp_id_q;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_mul3_arbiter.sv
// Bench for mul3_arbiter: a transaction-level model checked every cycle, plus directed scenarios
// with literal expectations.
module tb_mul3_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [11:0] req_a, req_b;
   logic [3:0]  req_ready;
   logic        rsp_valid, rsp_ready;
   logic [1:0]  rsp_id;
   logic [5:0]  rsp_p;
   logic        busy;
   logic [7:0]  op_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: phase 0 idle, 1 multiplying, 2 holding a response.
   int m_phase, m_ptr, m_id, m_p, m_cnt;
   int g_log[$];
   int c_p[$];
   int c_id[$];

   mul3_arbiter #(.NREQ(4), .IDW(2)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_p(rsp_p), .busy(busy), .op_count(op_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [3:0] v, input int p);
      for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   function automatic int prod(input int g);
      return int'(req_a[3*g +: 3]) * int'(req_b[3*g +: 3]);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0;
         m_ptr   <= 0;
         m_cnt   <= 0;
      end else begin
         case (m_phase)
            0: if (pick(req_valid, m_ptr) >= 0) begin
               m_id    <= pick(req_valid, m_ptr);
               m_p     <= prod(pick(req_valid, m_ptr));
               m_ptr   <= (pick(req_valid, m_ptr) + 1) % 4;
               m_phase <= 1;
               g_log.push_back(pick(req_valid, m_ptr));
            end
            1: m_phase <= 2;
            default: if (rsp_ready) begin
               m_cnt   <= (m_cnt + 1) % 256;
               m_phase <= 0;
               c_p.push_back(m_p);
               c_id.push_back(m_id);
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         check("reset req_ready", req_ready, 0);
         check("reset rsp_valid", rsp_valid, 0);
         check("reset busy", busy, 0);
         check("reset op_count", op_count, 0);
         check("reset rsp_p", rsp_p, 0);
         check("reset rsp_id", rsp_id, 0);
      end else begin
         check("req_ready", req_ready,
               (m_phase == 0 && pick(req_valid, m_ptr) >= 0) ? (1 << pick(req_valid, m_ptr)) : 0);
         check("rsp_valid", rsp_valid, m_phase == 2);
         check("busy", busy, m_phase != 0);
         check("op_count", op_count, m_cnt);
         if (m_phase == 2) begin
            check("rsp_p", rsp_p, m_p);
            check("rsp_id", rsp_id, m_id);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Requesters drop valid once they have seen their req_ready, unless told to keep it.
   task automatic cycle_drop(input bit keep);
      logic [3:0] rr;
      @(negedge clk);
      rr = req_ready;
      @(posedge clk);
      #1;
      if (!keep) req_valid = req_valid & ~rr;
   endtask

   task automatic wait_grants(input int n, input bit keep, input string name);
      int t = 0;
      while (g_log.size() < n && t < 200) begin
         cycle_drop(keep);
         t++;
      end
      check(name, g_log.size(), n);
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      while ((busy || m_phase != 0) && t < 50) begin
         tick();
         t++;
      end
      check(name, busy, 0);
   endtask

   task automatic clear_logs();
      g_log.delete();
      c_p.delete();
      c_id.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int t;
      int exp_p[5] = '{7, 14, 21, 28, 7};
      rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      check("idle busy", busy, 0);
      check("idle op_count", op_count, 0);

      // Single request on requester 2
      rsp_ready = 1'b1;
      clear_logs();
      req_a[8:6] = 3'd5; req_b[8:6] = 3'd6; req_valid = 4'b0100;
      wait_grants(1, 1'b0, "single grant wait");
      wait_idle("single drain");
      check("single grant id", g_log[0], 2);
      check("single product", c_p[0], 30);
      check("single rsp_id", c_id[0], 2);
      check("single op_count", op_count, 1);

      // Round-robin from a fresh pointer
      do_reset();
      clear_logs();
      for (int i = 0; i < 4; i++) begin
         req_a[3*i +: 3] = 3'(i + 1);
         req_b[3*i +: 3] = 3'd7;
      end
      req_valid = 4'hF;
      wait_grants(5, 1'b1, "rr grant wait");
      req_valid = '0;
      wait_idle("rr drain");
      for (int k = 0; k < 5; k++) begin
         check("rr grant order", g_log[k], k % 4);
         check("rr product", c_p[k], exp_p[k]);
      end

      // Backpressure; pointer now sits at 1
      rsp_ready = 1'b0;
      clear_logs();
      req_a[2:0] = 3'd7; req_b[2:0] = 3'd7; req_valid = 4'b0001;
      wait_grants(1, 1'b0, "bp grant wait");
      t = 0;
      while (!rsp_valid && t < 10) begin
         tick();
         t++;
      end
      req_a[5:3] = 3'd1; req_b[5:3] = 3'd2; req_valid = 4'b0010;
      repeat (5) begin
         @(negedge clk);
         check("bp rsp_p", rsp_p, 49);
         check("bp rsp_id", rsp_id, 0);
         check("bp req_ready", req_ready, 0);
         @(posedge clk);
         #1;
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      @(negedge clk);
      check("bp rsp_valid fell", rsp_valid, 0);
      check("bp next grant", req_ready, 4'b0010);
      @(posedge clk);
      #1;
      req_valid = '0;
      rsp_ready = 1'b1;
      wait_idle("bp drain");
      check("bp op_count", op_count, 7);

      // Reset while in MUL
      clear_logs();
      req_a[8:6] = 3'd3; req_b[8:6] = 3'd3; req_valid = 4'b0100;
      wait_grants(1, 1'b0, "midop grant wait");
      rst_n = 1'b0;
      req_valid = '0;
      req_a[5:3] = 3'd2;  req_b[5:3] = 3'd3;
      req_a[11:9] = 3'd4; req_b[11:9] = 3'd5;
      repeat (2) tick();
      req_valid = 4'b1010;
      tick();
      clear_logs();
      rst_n = 1'b1;
      wait_grants(2, 1'b0, "midop regrant wait");
      wait_idle("midop drain");
      check("midop first grant", g_log[0], 1);
      check("midop second grant", g_log[1], 3);
      check("midop product 1", c_p[0], 6);
      check("midop product 3", c_p[1], 20);
      check("midop responses", c_p.size(), 2);

      // All 64 operand pairs, then fill to 256 completions since reset
      clear_logs();
      for (int a = 0; a < 8; a++) begin
         for (int b = 0; b < 8; b++) begin
            req_a[2:0] = 3'(a); req_b[2:0] = 3'(b); req_valid = 4'b0001;
            t = 0;
            while (req_valid[0] && t < 20) begin
               cycle_drop(1'b0);
               t++;
            end
         end
      end
      wait_idle("exh drain");
      check("exh count", c_p.size(), 64);
      for (int k = 0; k < 64; k++) check("exh product", c_p[k], (k / 8) * (k % 8));
      check("exh op_count", op_count, 66);
      for (int n = 0; n < 190; n++) begin
         req_a[2:0] = 3'($urandom_range(7)); req_b[2:0] = 3'($urandom_range(7));
         req_valid = 4'b0001;
         t = 0;
         while (req_valid[0] && t < 20) begin
            cycle_drop(1'b0);
            t++;
         end
      end
      wait_idle("wrap drain");
      check("wrap op_count", op_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d",
               n_checks, n_fail);
      $fatal(1);
   end

endmodule

// File: doc/mul3_arbiter.md
# mul3_arbiter

Round-robin arbiter and sequencer that shares one 3x3-bit unsigned multiplier datapath between NREQ requesters. Each requester presents operands with a valid/ready handshake. The block grants one requester at a time, latches its operands, registers the 6-bit product and holds it on a response port until the consumer accepts it. It sits between several client blocks and the single multiplier instance, so the multiplier never needs replicating.

## Interface
- NREQ, default 4: number of requesters; legal range 2..8.
- IDW, default 2: width of the requester index; must satisfy 2^IDW >= NREQ.
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req_valid, input, NREQ: bit i high means requester i has an operation pending.
- req_a, input, 3*NREQ: operand A; requester i uses bits [3i+2:3i].
- req_b, input, 3*NREQ: operand B; same packing as req_a.
- req_ready, output, NREQ: one-hot or zero; bit i high means requester i's operation is accepted this cycle.
- rsp_valid, output, 1: a product is held on the response port.
- rsp_ready, input, 1: consumer accepts the response.
- rsp_id, output, IDW: index of the requester that owns rsp_p.
- rsp_p, output, 6: unsigned product a*b, range 0..49.
- busy, output, 1: high whenever the block is not in IDLE.
- op_count, output, 8: count of completed responses; wraps 255 -> 0.

## Operation
- The FSM has three states: IDLE, MUL and RESP.
- IDLE:
  - If any req_valid bit is set, grant the first set bit found searching upward from ptr, wrapping modulo NREQ.
  - Drive req_ready for the granted bit only, combinationally from req_valid and ptr.
  - On the same edge, latch the operands and the id into op_a, op_b and op_id, then go to MUL.
  - Update ptr to (granted index + 1) mod NREQ.
  - If no req_valid bit is set, stay in IDLE; ptr is unchanged.
- MUL:
  - Register the full 6-bit product op_a*op_b into rsp_p and op_id into rsp_id.
  - Go to RESP unconditionally.
- RESP:
  - rsp_valid = 1. rsp_p and rsp_id stay stable until the handshake completes.
  - On rsp_valid & rsp_ready, increment op_count and go to IDLE.
  - Otherwise stay in RESP.
- req_ready is 0 in MUL and RESP, so there is no acceptance while busy. Pending requesters simply wait.
- Requesters hold req_valid and their operands until they see req_ready. If a requester drops req_valid before its grant, it is not serviced and causes no error.
- Product width rule: the product is computed at the full 6-bit width with no truncation; 7*7 = 49 = 6'b110001.
- Reset values (asynchronous, while rst_n = 0):
  - state = IDLE, ptr = 0, op_count = 0.
  - rsp_valid = 0, rsp_p = 0, rsp_id = 0, busy = 0.
  - req_ready = 0 for the whole reset duration.
  - op_a, op_b and op_id = 0.
- Reset mid-operation: any in-flight operation is discarded with no response. The first grant after reset is searched from index 0.

## Timing
- Accept edge is T (req_ready high in the cycle before T).
- The block is in MUL during cycle T, and rsp_valid rises in cycle T+1. Latency from accept to response is 2 cycles.
- If rsp_ready is high in the first RESP cycle, the block is back in IDLE in the next cycle, which can grant again. Peak throughput is one operation per 3 cycles.
- Backpressure: each cycle rsp_ready stays low extends RESP by one cycle. No data changes during the stall.
- Fairness: while all requesters stay asserted, grants cycle 0,1,...,NREQ-1,0. Any requester holding valid is granted within NREQ operations.
- A request arriving in the same cycle as the RESP handshake is not granted that cycle. It is evaluated in the following IDLE cycle.
- op_count updates on the handshake edge. It reads 255 -> 0 on the 256th completion.

## Test plan
- Reset and idle:
  - Hold rst_n low, release it with req_valid = 0.
  - Required: all outputs 0, busy = 0, no req_ready for 10 cycles.
- Single request:
  - Requester 2 sends a = 5, b = 6, with rsp_ready held high.
  - Required: req_ready = 4'b0100 for one cycle; rsp_valid two cycles later with rsp_p = 30 and rsp_id = 2; op_count = 1.
- Round-robin:
  - All four requesters are valid continuously; requester i sends a = i+1, b = 7.
  - Required: grants in order 0,1,2,3,0; products 7, 14, 21, 28, 7.
- Backpressure:
  - Send a = 7, b = 7 and hold rsp_ready low for 5 cycles.
  - Required: rsp_p = 49 and rsp_id held stable; req_ready stays 0 throughout.
  - Then raise rsp_ready for one cycle. Required: rsp_valid falls and the next grant comes one cycle later.
- Reset mid-operation:
  - Assert rst_n low while in MUL.
  - Required: rsp_valid never rises; after release, with requesters 1 and 3 valid, requester 1 is granted first because ptr = 0.
- Exhaustive values and wrap:
  - Run all 64 a/b pairs through requester 0, then continue to 256 completions.
  - Required: every product exact, and op_count wraps to 0.
